// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
//   Shared types and helpers for the round-robin arbiter.
//   - arb_state_t : arbiter FSM state encoding
//   - idx_w()     : width of a binary index into N requesters (minimum 1)
// ---------------------------------------------------------------------------
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational masked priority picker for round-robin arbitration.
//   Looks for the lowest set request at index >= ptr. If there is none, it
//   wraps and takes the lowest set request overall.
// Ports
//   req    in   N    request vector
//   ptr    in   IW   rotating priority pointer
//   onehot out  N    one-hot pick (zero when any=0)
//   idx    out  IW   binary index of the pick (zero when any=0)
//   any    out  1    at least one request is set
// ---------------------------------------------------------------------------
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0]  mask;
    logic [N-1:0]  masked_req;
    logic [IW-1:0] masked_idx;
    logic          masked_any;
    logic [IW-1:0] plain_idx;
    logic          plain_any;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
    end

    assign masked_req = req & mask;

    // Scan from the top down so the last assignment is the lowest set bit.
    always_comb begin
        masked_idx = '0;
        masked_any = 1'b0;
        plain_idx  = '0;
        plain_any  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (masked_req[i]) begin
                masked_idx = IW'(i);
                masked_any = 1'b1;
            end
            if (req[i]) begin
                plain_idx = IW'(i);
                plain_any = 1'b1;
            end
        end
    end

    always_comb begin
        onehot = '0;
        idx    = masked_any ? masked_idx : plain_idx;
        any    = plain_any;
        if (plain_any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_param.sv
// ---------------------------------------------------------------------------
// rr_arbiter_param
//   Round-robin arbiter for N requesters with packet-level grant locking.
//   A winner holds a registered one-hot grant until it signals done or drops
//   its request; priority then rotates to the index after the winner.
//   Optional feature macro: RR_WEIGHT_EN (weighted round robin, each winner
//   keeps the grant for up to weight[i] packets; weight 0 counts as 1).
// Ports
//   clk        in   1           clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   req        in   N           level-sensitive request vector
//   done       in   1           holder finished its packet
//   weight     in   N*WEIGHT_W  packets per turn per requester
//   gnt        out  N           registered one-hot grant
//   gnt_valid  out  1           gnt is non-zero
//   gnt_id     out  IW          binary index of the holder (0 when idle)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; pick the next requester starting at ptr
// BUSY  | grant held; wait for done or abort (holder drops its req)
// ---------------------------------------------------------------------------
module rr_arbiter_param
    import rr_arb_pkg::*;
#(
    parameter  int N        = 8,
    parameter  int WEIGHT_W = 4,
    localparam int IW       = idx_w(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req,
    input  logic                  done,
    input  logic [N*WEIGHT_W-1:0] weight,
    output logic [N-1:0]          gnt,
    output logic                  gnt_valid,
    output logic [IW-1:0]         gnt_id
);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] id_q, id_d;
    logic          valid_q, valid_d;
    logic          release_c;
    logic [IW-1:0] next_ptr;

    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign next_ptr = (id_q == IW'(N - 1)) ? '0 : id_q + IW'(1);

`ifdef RR_WEIGHT_EN
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [WEIGHT_W-1:0] win_weight;

    always_comb begin
        win_weight = weight[int'(pick_idx) * WEIGHT_W +: WEIGHT_W];
        if (win_weight == '0) begin
            win_weight = WEIGHT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end
`else
    // Every turn is a single packet; the weight port is accepted but unused.
    logic unused_weight;
    assign unused_weight = ^weight;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        valid_d   = valid_q;
        release_c = 1'b0;
`ifdef RR_WEIGHT_EN
        credit_d  = credit_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_onehot;
                    id_d    = pick_idx;
                    valid_d = 1'b1;
                    state_d = BUSY;
`ifdef RR_WEIGHT_EN
                    credit_d = win_weight;
`endif
                end
            end
            BUSY: begin
                if (!req[id_q]) begin
                    release_c = 1'b1;
                end else if (done) begin
`ifdef RR_WEIGHT_EN
                    // More packets left in this turn: keep the grant, ptr stays.
                    if (credit_q > WEIGHT_W'(1)) begin
                        credit_d = credit_q - WEIGHT_W'(1);
                    end else begin
                        release_c = 1'b1;
                    end
`else
                    release_c = 1'b1;
`endif
                end
                if (release_c) begin
                    ptr_d   = next_ptr;
                    gnt_d   = '0;
                    id_d    = '0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_param
//   Directed bench for rr_arbiter_param with N=8. Inputs change and outputs
//   are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_param;

    localparam int N        = 8;
    localparam int WEIGHT_W = 4;

    logic                  clk;
    logic                  rst_n;
    logic [N-1:0]          req;
    logic                  done;
    logic [N*WEIGHT_W-1:0] weight;
    logic [N-1:0]          gnt;
    logic                  gnt_valid;
    logic [2:0]            gnt_id;

    int n_checks = 0;
    int n_errors = 0;

    rr_arbiter_param #(
        .N        (N),
        .WEIGHT_W (WEIGHT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .weight    (weight),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks grant, valid and id together for an expected one-hot (or zero).
    task automatic check_gnt(input string tag, input logic [7:0] exp_gnt, input logic [2:0] exp_id);
        check_val({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check_val({tag, "_valid"}, 32'(gnt_valid), 32'(exp_gnt != 8'h00));
        check_val({tag, "_id"}, 32'(gnt_id), 32'(exp_id));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        done   = 1'b0;
        weight = '0;
        #12;
        check_gnt("reset", 8'h00, 3'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check_gnt("idle_noreq", 8'h00, 3'd0);

        // Test 1: single request, one-cycle latency.
        req = 8'h01;
        tick();
        check_gnt("t1_grant0", 8'h01, 3'd0);
        done = 1'b1;
        tick();
        check_gnt("t1_release", 8'h00, 3'd0);
        done = 1'b0;

        // Test 2: full rotation from ptr=0 with all requesting.
        req = '0;
        do_reset();
        req = 8'hFF;
        for (int k = 0; k <= 8; k++) begin
            tick();
            check_gnt($sformatf("t2_grant%0d", k), 8'(1 << (k % 8)), 3'(k % 8));
            done = 1'b1;
            tick();
            check_gnt($sformatf("t2_gap%0d", k), 8'h00, 3'd0);
            done = 1'b0;
        end
        // ptr is now 1.

        // Test 3: holder 3, wrap past 4..7 to index 0, then back to 3.
        req = 8'h08;
        tick();
        check_gnt("t3_hold3", 8'h08, 3'd3);
        req  = 8'h09;
        done = 1'b1;
        tick();
        check_gnt("t3_rel3", 8'h00, 3'd0);
        done = 1'b0;
        tick();
        check_gnt("t3_wrap0", 8'h01, 3'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check_gnt("t3_back3", 8'h08, 3'd3);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        // ptr is now 4.

        // Test 4: holder 5, non-holder noise ignored, abort by dropping req[5].
        req = 8'h20;
        tick();
        check_gnt("t4_hold5", 8'h20, 3'd5);
        req = 8'h21;
        tick();
        check_gnt("t4_noise", 8'h20, 3'd5);
        req = 8'h01;
        tick();
        check_gnt("t4_abort", 8'h00, 3'd0);
        req = 8'h41;
        tick();
        check_gnt("t4_ptr6", 8'h40, 3'd6);
        req = 8'h00;
        tick();
        check_gnt("t4_abort6", 8'h00, 3'd0);

        // Test 5: asynchronous reset mid-packet, then grant at index 7 and wrap.
        req = 8'h20;
        tick();
        check_gnt("t5_hold5", 8'h20, 3'd5);
        #2 rst_n = 1'b0;
        #1;
        check_gnt("t5_async", 8'h00, 3'd0);
        req = 8'h80;
        #1 rst_n = 1'b1;
        tick();
        check_gnt("t5_grant7", 8'h80, 3'd7);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'hFF;
        tick();
        check_gnt("t5_wrap_ptr0", 8'h01, 3'd0);
        req = 8'h00;
        tick();

        // Test 6: weight field 0 = 3, field 1 = 0.
        do_reset();
        weight = 32'h0000_0003;
        req    = 8'h03;
        tick();
        check_gnt("t6_grant0", 8'h01, 3'd0);
        done = 1'b1;
`ifdef RR_WEIGHT_EN
        tick();
        check_gnt("t6_pkt2", 8'h01, 3'd0);
        tick();
        check_gnt("t6_pkt3", 8'h01, 3'd0);
`endif
        tick();
        check_gnt("t6_release0", 8'h00, 3'd0);
        done = 1'b0;
        tick();
        check_gnt("t6_grant1", 8'h02, 3'd1);
        done = 1'b1;
        tick();
        check_gnt("t6_weight0_is1", 8'h00, 3'd0);
        done = 1'b0;
        req  = 8'h00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
